// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types, constants and address check for the data-memory responder
// Contents: responder state enum, wait-counter width, default base address,
// and the range/alignment legality check used when a request is latched.
// Optional feature macro: MEM_ALIGN_CHECK_EN makes byte addresses with
// data_address[1:0] != 0 illegal.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int          CNT_W             = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // Legal when the address is at or above base and its word index fits in
  // 2^addr_w words.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          addr_w);
    logic [31:0] off;
    logic        ok;
    off = addr - base;
    ok  = (addr >= base) && ((off >> (addr_w + 2)) == 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    ok  = ok && (addr[1:0] == 2'b00);
`else
    ok  = ok;
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mips_mem_ram_sp.sv
// rtl/mips_mem_ram_sp.sv - single-port word RAM, synchronous write, asynchronous read
// Ports:
//   clk_i   : write clock, rising edge
//   we_i    : write enable
//   addr_i  : word address (shared by read and write)
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// Contents are never cleared.
module mips_mem_ram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mips_cpu_data_mem_responder.sv
// rtl/mips_cpu_data_mem_responder.sv - wait-state data-memory responder for the CPU data port
// Serves one read or write per access from an internal word RAM, stalling
// the CPU via clk_enable for WAIT_CYCLES+1 cycles per access.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses fault).
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   active         : CPU active; requests ignored while low
//   data_address   : byte address
//   data_read      : read request
//   data_write     : write request (wins over data_read)
//   data_writedata : write data
//   data_readdata  : read data, nonzero only in RESP for a legal read
//   clk_enable     : CPU advance enable, low stalls the CPU
//   fault          : sticky illegal-access flag
module mips_cpu_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        fault
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                legal_q, legal_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                fault_q;
  logic                req;
  logic                ram_we;
  logic [31:0]         ram_rdata;

  assign req = active & (data_read | data_write);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      legal_q <= legal_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      fault_q <= fault;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    legal_d    = legal_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    clk_enable = 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Stall in the request cycle itself so the CPU holds its outputs.
          clk_enable = 1'b0;
          write_d    = data_write;
          legal_d    = addr_legal(data_address, BASE_ADDR, ADDR_W);
          idx_d      = ADDR_W'((data_address - BASE_ADDR) >> 2);
          wdata_d    = data_writedata;
          cnt_d      = WAIT_LOAD;
          state_d    = (WAIT_CYCLES == 0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        clk_enable = 1'b0;
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The CPU must never be frozen while it is itself held in reset.
    if (!reset) begin
      clk_enable = 1'b1;
    end
  end

  // Write commits at the edge ending RESP; illegal writes are dropped.
  assign ram_we = (state_q == RESP) && write_q && legal_q;

  assign data_readdata = ((state_q == RESP) && !write_q && legal_q) ? ram_rdata : 32'h0;

  // Visible already in RESP, then held by fault_q until reset.
  assign fault = fault_q | ((state_q == RESP) && !legal_q);

  mips_mem_ram_sp #(
    .DEPTH (1 << ADDR_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule
